// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: FSM state encoding and fetch constants shared by the fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_e;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          PC_INC = 4;

endpackage

// File: rtl/fetch_unit_pc_register.sv
// pc_register: program counter with redirect/increment/hold next-PC selection.
module pc_register
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            inc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q, pc_d;

    // Increment wraps naturally modulo 2^XLEN.
    always_comb pc_d = load_i ? target_i : inc_i ? pc_q + XLEN'(PC_INC) : pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-stage instruction fetch with decode handshake, redirect and misaligned-target fault.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_fault
);

    state_e          state_q, state_d;
    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [XLEN-1:0] pc;
    logic            redir, aligned, advance;

    // Redirects are only honoured once out of IDLE.
    assign redir   = redirect_valid && (state_q != IDLE);
    assign aligned = (redirect_target[1:0] == 2'b00);
    assign advance = (state_q == RUN) && !stall && (!valid_q || instr_ready) && !redirect_valid;

    pc_register #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load_i   (redir && aligned),
        .target_i (redirect_target),
        .inc_i    (advance),
        .pc_o     (pc)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        if (state_q == IDLE) begin
            state_d = RUN;
        end else if (redir) begin
            valid_d = 1'b0;
            state_d = aligned ? RUN : FAULT;
        end else if (advance) begin
            instr_d = imem_data;
            ipc_d   = pc;
            valid_d = 1'b1;
        end else if (state_q == RUN && valid_q && instr_ready) begin
            // Consumed while stalled: nothing new to present next cycle.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            instr_q <= NOP;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    assign imem_addr   = pc;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tests for fetch_unit against a small combinational instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;
    logic [97:0] obs, exp;

    always #5 clk = ~clk;

    // Words 0x11/0x22/0x33 at 0/4/8; elsewhere the word is a known function of the address.
    assign imem_data = (imem_addr == 32'h0) ? 32'h11 :
                       (imem_addr == 32'h4) ? 32'h22 :
                       (imem_addr == 32'h8) ? 32'h33 : (32'hA000_0000 ^ imem_addr);

    assign obs = {instr_valid, instr, instr_pc, imem_addr, fetch_fault};

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .fetch_fault     (fetch_fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; redirect_valid = 1'b0; redirect_target = '0; stall = 1'b0; instr_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        exp = {1'b0, 32'h13, 32'h0, 32'h0, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL reset got=%h exp=%h", obs, exp); end
        total++;
        rst = 1'b1;
        step();
        exp = {1'b0, 32'h13, 32'h0, 32'h0, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL idle_cycle got=%h exp=%h", obs, exp); end
        total++;
    endtask

    task automatic test_sequential();
        step();
        exp = {1'b1, 32'h11, 32'h0, 32'h4, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL seq0 got=%h exp=%h", obs, exp); end
        total++;
        step();
        exp = {1'b1, 32'h22, 32'h4, 32'h8, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL seq1 got=%h exp=%h", obs, exp); end
        total++;
        step();
        exp = {1'b1, 32'h33, 32'h8, 32'hC, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL seq2 got=%h exp=%h", obs, exp); end
        total++;
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp = {1'b1, 32'h33, 32'h8, 32'hC, 1'b0};
            if (obs !== exp) begin bad++; $display("FAIL hold%0d got=%h exp=%h", i, obs, exp); end
            total++;
        end
        instr_ready = 1'b1;
        step();
        exp = {1'b1, 32'hA000_000C, 32'hC, 32'h10, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL resume got=%h exp=%h", obs, exp); end
        total++;
    endtask

    task automatic test_redirect_stall();
        redirect_valid = 1'b1; redirect_target = 32'h40; stall = 1'b1;
        step();
        exp = {1'b0, 32'hA000_000C, 32'hC, 32'h40, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL redir_flush got=%h exp=%h", obs, exp); end
        total++;
        redirect_valid = 1'b0; stall = 1'b0;
        step();
        exp = {1'b1, 32'hA000_0040, 32'h40, 32'h44, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL redir_fetch got=%h exp=%h", obs, exp); end
        total++;
    endtask

    task automatic test_stall_accept();
        stall = 1'b1;
        step();
        exp = {1'b0, 32'hA000_0040, 32'h40, 32'h44, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL stall_drop got=%h exp=%h", obs, exp); end
        total++;
        step();
        if (obs !== exp) begin bad++; $display("FAIL stall_hold got=%h exp=%h", obs, exp); end
        total++;
        stall = 1'b0;
        step();
        exp = {1'b1, 32'hA000_0044, 32'h44, 32'h48, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL stall_resume got=%h exp=%h", obs, exp); end
        total++;
    endtask

    task automatic test_fault();
        redirect_valid = 1'b1; redirect_target = 32'h42;
        step();
        exp = {1'b0, 32'hA000_0044, 32'h44, 32'h48, 1'b1};
        if (obs !== exp) begin bad++; $display("FAIL fault_set got=%h exp=%h", obs, exp); end
        total++;
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (obs !== exp) begin bad++; $display("FAIL fault_hold%0d got=%h exp=%h", i, obs, exp); end
            total++;
        end
        redirect_valid = 1'b1; redirect_target = 32'h80;
        step();
        exp = {1'b0, 32'hA000_0044, 32'h44, 32'h80, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL fault_clear got=%h exp=%h", obs, exp); end
        total++;
        redirect_valid = 1'b0;
        step();
        exp = {1'b1, 32'hA000_0080, 32'h80, 32'h84, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL fault_refetch got=%h exp=%h", obs, exp); end
        total++;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        exp = {1'b0, 32'hA000_0080, 32'h80, 32'hFFFF_FFFC, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL wrap_load got=%h exp=%h", obs, exp); end
        total++;
        redirect_valid = 1'b0;
        step();
        exp = {1'b1, 32'h5FFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL wrap_top got=%h exp=%h", obs, exp); end
        total++;
        step();
        exp = {1'b1, 32'h11, 32'h0, 32'h4, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL wrap_zero got=%h exp=%h", obs, exp); end
        total++;
    endtask

    task automatic test_reset_midstream();
        step();
        rst = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40;
        #1;
        exp = {1'b0, 32'h13, 32'h0, 32'h0, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs, exp); end
        total++;
        @(negedge clk);
        rst = 1'b1;
        step();
        if (obs !== exp) begin bad++; $display("FAIL idle_ignores_redir got=%h exp=%h", obs, exp); end
        total++;
        redirect_valid = 1'b0;
        step();
        exp = {1'b1, 32'h11, 32'h0, 32'h4, 1'b0};
        if (obs !== exp) begin bad++; $display("FAIL post_reset_fetch got=%h exp=%h", obs, exp); end
        total++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_stall();
        test_stall_accept();
        test_fault();
        test_wrap();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the address and PC width.
REQ-002 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port redirect_valid, input, 1 bit, meaning a branch/jump redirect request.
REQ-006 The block SHALL have port redirect_target, input, XLEN bits, meaning the new PC when redirect_valid=1.
REQ-007 The block SHALL have port stall, input, 1 bit, meaning freeze the PC and output register.
REQ-008 The block SHALL have port imem_addr, output, XLEN bits, meaning the byte address to the instruction memory; it always equals pc.
REQ-009 The block SHALL have port imem_data, input, 32 bits, meaning the instruction word returned combinationally for imem_addr.
REQ-010 The block SHALL have port instr_valid, output, 1 bit, meaning instr/instr_pc hold a valid fetched instruction.
REQ-011 The block SHALL have port instr_ready, input, 1 bit, meaning decode accepts the instruction this cycle.
REQ-012 The block SHALL have port instr, output, 32 bits, meaning the registered instruction word.
REQ-013 The block SHALL have port instr_pc, output, XLEN bits, meaning the address instr was fetched from.
REQ-014 The block SHALL have port fetch_fault, output, 1 bit, meaning a misaligned redirect target was received.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and FAULT; reset enters IDLE; IDLE->RUN unconditionally on the next edge; no fetch is captured in IDLE.
REQ-016 advance SHALL be RUN && !stall && (!instr_valid || instr_ready).
REQ-017 On advance without redirect: instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4, giving one-cycle latency from imem_addr to instr.
REQ-018 pc+4 SHALL wrap modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 for XLEN=32).
REQ-019 When instr_valid=1, instr_ready=1 and advance is blocked by stall, instr_valid SHALL clear to 0 on the next edge; otherwise an unaccepted instruction is held stable.
REQ-020 With instr_valid=1 and instr_ready=0, instr, instr_pc and pc SHALL hold unchanged.
REQ-021 redirect_valid SHALL take priority over stall and advance in RUN or FAULT: pc<=redirect_target, instr_valid<=0 (flush), and the instruction currently on imem_data SHALL be discarded.
REQ-022 A redirect with redirect_target[1:0]!=0 SHALL leave pc unchanged, set fetch_fault<=1, and enter FAULT.
REQ-023 In FAULT the block SHALL perform no fetch and keep instr_valid=0; only an aligned redirect SHALL return it to RUN and clear fetch_fault.
REQ-024 A redirect in IDLE SHALL be ignored.

Reset
REQ-025 While rst=0: pc=RESET_PC, instr=32'h00000013 (NOP), instr_pc=0, instr_valid=0, fetch_fault=0, state=IDLE, applied asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard any held instruction and pending redirect; fetch SHALL resume at RESET_PC one cycle after release.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the NOP constant 32'h00000013 and the PC increment constant 4.
REQ-028 A single sub-module pc_register SHALL hold the PC and its next-PC mux (redirect/increment/hold); instruction_memory SHALL be instantiated outside fetch_unit.

Verification
REQ-029 Reset release, RESET_PC=0, memory words 0x11,0x22,0x33, ready=1 -> cycle 1 IDLE; then instr=0x11/pc 0, 0x22/pc 4, 0x33/pc 8 on consecutive cycles.
REQ-030 instr_ready=0 for 3 cycles with instr_valid=1 -> instr, instr_pc and imem_addr stable; fetch resumes at the next address when ready=1.
REQ-031 redirect_valid=1 with target 0x40, simultaneous with stall=1 -> next cycle pc=0x40, instr_valid=0; the following cycle instr_pc=0x40.
REQ-032 Redirect to 0x42 -> fetch_fault=1, instr_valid=0 held; a later redirect to 0x80 -> fetch_fault=0 and instr_pc=0x80 one cycle later.
REQ-033 pc forced to 0xFFFFFFFC via redirect -> the next fetch address is 0x00000000.
REQ-034 rst pulsed low mid-stream with instr_valid=1 -> outputs go to reset values immediately; first post-reset instr_pc=RESET_PC.
